// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, register file with write-before-read
// bypass, load-use stall, branch resolution and the registered ID/EX bundle.
module id_stage #(
  parameter int REG_COUNT = 16,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] instruction,
  input  logic              wbEn,
  input  logic [3:0]        wbDest,
  input  logic [DATA_W-1:0] wbData,
  input  logic              exMemRead,
  input  logic [3:0]        exDest,
  output logic              freeze,
  output logic              brTaken,
  output logic [DATA_W-1:0] brOffset,
  output logic [DATA_W-1:0] idPC,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB,
  output logic [DATA_W-1:0] imm,
  output logic [3:0]        dest,
  output logic [3:0]        aluOp,
  output logic              memRead,
  output logic              memWrite,
  output logic              regWrite,
  output logic              valid
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;

  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
    return DATA_W'($signed(v));
  endfunction

  logic [DATA_W-1:0] regs [REG_COUNT];

  logic [DATA_W-1:0] pc_p0;
  logic [DATA_W-1:0] instr_p0;
  logic              vld_p0;

  logic [3:0]               op_p0, rd_p0, rs1_p0, rs2_p0;
  logic signed [DATA_W-1:0] imm_sx_p0;
  logic [DATA_W-1:0]        rs1_val_p0, rs2_val_p0;
  logic                     use1_p0, use2_p0;
  logic                     legal_p0, writes_rd_p0;

  assign op_p0     = instr_p0[31:28];
  assign rd_p0     = instr_p0[27:24];
  assign rs1_p0    = instr_p0[23:20];
  assign rs2_p0    = instr_p0[19:16];
  assign imm_sx_p0 = sext16(instr_p0[15:0]);

  // Register read with same-cycle writeback bypass; r0 is hardwired to zero.
  always_comb begin
    rs1_val_p0 = regs[rs1_p0];
    if (wbEn && (wbDest == rs1_p0)) rs1_val_p0 = wbData;
    if (rs1_p0 == 4'd0) rs1_val_p0 = '0;
    rs2_val_p0 = regs[rs2_p0];
    if (wbEn && (wbDest == rs2_p0)) rs2_val_p0 = wbData;
    if (rs2_p0 == 4'd0) rs2_val_p0 = '0;
  end

  always_comb begin
    use1_p0 = 1'b0;
    use2_p0 = 1'b0;
    case (op_p0)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SW, OP_BEQ, OP_BNE: begin
        use1_p0 = 1'b1;
        use2_p0 = 1'b1;
      end
      OP_ADDI, OP_LW: use1_p0 = 1'b1;
      default: ;
    endcase
  end

  assign legal_p0     = (op_p0 != OP_NOP) && (op_p0 <= OP_JMP);
  assign writes_rd_p0 = (op_p0 >= OP_ADD) && (op_p0 <= OP_LW);

  assign freeze = vld_p0 && exMemRead && (exDest != 4'd0) &&
                  ((use1_p0 && (exDest == rs1_p0)) || (use2_p0 && (exDest == rs2_p0)));

  assign brTaken = vld_p0 && !freeze &&
                   ((op_p0 == OP_JMP) ||
                    ((op_p0 == OP_BEQ) && (rs1_val_p0 == rs2_val_p0)) ||
                    ((op_p0 == OP_BNE) && (rs1_val_p0 != rs2_val_p0)));

  assign brOffset = {imm_sx_p0[DATA_W-3:0], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wbEn && (wbDest != 4'd0)) begin
      regs[wbDest] <= wbData;
    end
  end

  // Stage p0: IF/ID register (holds on stall, squashed on taken branch)
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_p0    <= '0;
      instr_p0 <= '0;
      vld_p0   <= 1'b0;
    end else if (!freeze) begin
      if (brTaken) begin
        pc_p0    <= '0;
        instr_p0 <= '0;
        vld_p0   <= 1'b0;
      end else begin
        pc_p0    <= PC;
        instr_p0 <= instruction;
        vld_p0   <= 1'b1;
      end
    end
  end

  // Stage p1: ID/EX register (a stall inserts an all-zero bubble)
  always_ff @(posedge clk) begin
    if (!rst || freeze) begin
      idPC     <= '0;
      opA      <= '0;
      opB      <= '0;
      imm      <= '0;
      dest     <= '0;
      aluOp    <= '0;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      regWrite <= 1'b0;
      valid    <= 1'b0;
    end else begin
      idPC     <= pc_p0;
      opA      <= rs1_val_p0;
      opB      <= rs2_val_p0;
      imm      <= imm_sx_p0;
      dest     <= writes_rd_p0 ? rd_p0 : 4'd0;
      aluOp    <= legal_p0 ? op_p0 : OP_NOP;
      memRead  <= (op_p0 == OP_LW);
      memWrite <= (op_p0 == OP_SW);
      regWrite <= writes_rd_p0;
      valid    <= vld_p0 && legal_p0;
    end
  end

endmodule
